// File: rtl/dest_compare_unit_pkg.sv
// Shared constants and helpers for the destination compare unit.
// The default widths live here so the top, the interface and the compare cell stay in agreement.
package dcu_pkg;

    localparam int DCU_ADDR_W    = 8;
    localparam int DCU_NUM_PORTS = 4;
    localparam int DCU_CNT_W     = 16;

    // Ceiling log2. Kept local so the port index width can be derived the same way everywhere.
    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/dest_compare_unit_if.sv
// Valid/ready bus between the packet deframer, the destination compare unit and the port arbiter.
// The master side drives addresses and accepts results; the slave side is the compare unit.
interface dest_compare_unit_if
    import dcu_pkg::*;
#(
    parameter int ADDR_W    = DCU_ADDR_W,
    parameter int NUM_PORTS = DCU_NUM_PORTS
);

    localparam int IDX_W = clog2(NUM_PORTS);

    logic                 in_valid;
    logic                 in_ready;
    logic [ADDR_W-1:0]    in_addr;
    logic                 out_valid;
    logic                 out_ready;
    logic [NUM_PORTS-1:0] out_match;
    logic                 out_hit;
    logic [IDX_W-1:0]     out_port;

    modport master (
        output in_valid,
        output in_addr,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_match,
        input  out_hit,
        input  out_port
    );

    modport slave (
        input  in_valid,
        input  in_addr,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_match,
        output out_hit,
        output out_port
    );

endinterface

// File: rtl/dest_compare_unit_addr_cmp_cell.sv
// Single combinational destination compare: one reference entry against the incoming address.
// Mask bits set to 1 are don't-care; a tied-off zero mask gives an exact equality compare.
module addr_cmp_cell
    import dcu_pkg::*;
#(
    parameter int ADDR_W = DCU_ADDR_W
) (
    input  logic [ADDR_W-1:0] ref_addr_i,
    input  logic [ADDR_W-1:0] ref_mask_i,
    input  logic              ref_en_i,
    input  logic [ADDR_W-1:0] addr_i,
    output logic              match_o
);

    logic [ADDR_W-1:0] diffBits;

    assign diffBits = (addr_i ^ ref_addr_i) & ~ref_mask_i;
    assign match_o  = ref_en_i && (diffBits == '0);

endmodule

// File: rtl/dest_compare_unit.sv
// Registered multi-port destination comparator: port table, parallel compare, priority encode, miss counter.
// Optional per-entry don't-care masks are built in when DCU_MASK_EN is defined.
module dest_compare_unit
    import dcu_pkg::*;
#(
    parameter int  ADDR_W    = DCU_ADDR_W,
    parameter int  NUM_PORTS = DCU_NUM_PORTS,
    parameter int  CNT_W     = DCU_CNT_W,
    localparam int IDX_W     = clog2(NUM_PORTS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_we_i,
    input  logic [IDX_W-1:0]  cfg_idx_i,
    input  logic [ADDR_W-1:0] cfg_addr_i,
    input  logic              cfg_en_i,
`ifdef DCU_MASK_EN
    input  logic [ADDR_W-1:0] cfg_mask_i,
`endif
    input  logic              cnt_clr_i,
    output logic [CNT_W-1:0]  miss_cnt_o,
    dest_compare_unit_if.slave bus
);

    logic [ADDR_W-1:0]    refAddr_q [NUM_PORTS];
    logic [NUM_PORTS-1:0] refEn_q;
    logic [ADDR_W-1:0]    cellMask  [NUM_PORTS];
    logic                 cfgIdxOk;

    logic [NUM_PORTS-1:0] match;
    logic                 hit;
    logic [IDX_W-1:0]     lowPort;

    logic                 inReady;
    logic                 accept;

    logic                 outValid_q, outValid_d;
    logic [NUM_PORTS-1:0] outMatch_q, outMatch_d;
    logic                 outHit_q,   outHit_d;
    logic [IDX_W-1:0]     outPort_q,  outPort_d;
    logic [CNT_W-1:0]     missCnt_q,  missCnt_d;

    assign cfgIdxOk = (int'(cfg_idx_i) < NUM_PORTS);

    // Table writes land at the clock edge, so a compare in the same cycle still sees the old entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                refAddr_q[i] <= '0;
            end
            refEn_q <= '0;
        end else if (cfg_we_i && cfgIdxOk) begin
            refAddr_q[cfg_idx_i] <= cfg_addr_i;
            refEn_q[cfg_idx_i]   <= cfg_en_i;
        end
    end

`ifdef DCU_MASK_EN
    logic [ADDR_W-1:0] refMask_q [NUM_PORTS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                refMask_q[i] <= '0;
            end
        end else if (cfg_we_i && cfgIdxOk) begin
            refMask_q[cfg_idx_i] <= cfg_mask_i;
        end
    end
`endif

    for (genvar g = 0; g < NUM_PORTS; g++) begin : gen_cmp
`ifdef DCU_MASK_EN
        assign cellMask[g] = refMask_q[g];
`else
        assign cellMask[g] = '0;
`endif
        addr_cmp_cell #(
            .ADDR_W(ADDR_W)
        ) u_cmp (
            .ref_addr_i(refAddr_q[g]),
            .ref_mask_i(cellMask[g]),
            .ref_en_i  (refEn_q[g]),
            .addr_i    (bus.in_addr),
            .match_o   (match[g])
        );
    end

    // Scan from the top down so the lowest matching index is the one left standing.
    always_comb begin
        lowPort = '0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (match[i]) begin
                lowPort = IDX_W'(i);
            end
        end
    end

    assign hit     = |match;
    assign inReady = !outValid_q || bus.out_ready;
    assign accept  = bus.in_valid && inReady;

    always_comb begin
        outValid_d = outValid_q;
        outMatch_d = outMatch_q;
        outHit_d   = outHit_q;
        outPort_d  = outPort_q;
        if (accept) begin
            outValid_d = 1'b1;
            outMatch_d = match;
            outHit_d   = hit;
            outPort_d  = lowPort;
        end else if (bus.out_ready) begin
            outValid_d = 1'b0;
        end
    end

    // Clear wins over a miss in the same cycle; the count sticks at all-ones instead of wrapping.
    always_comb begin
        missCnt_d = missCnt_q;
        if (cnt_clr_i) begin
            missCnt_d = '0;
        end else if (accept && !hit && (missCnt_q != '1)) begin
            missCnt_d = missCnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outValid_q <= 1'b0;
            outMatch_q <= '0;
            outHit_q   <= 1'b0;
            outPort_q  <= '0;
            missCnt_q  <= '0;
        end else begin
            outValid_q <= outValid_d;
            outMatch_q <= outMatch_d;
            outHit_q   <= outHit_d;
            outPort_q  <= outPort_d;
            missCnt_q  <= missCnt_d;
        end
    end

    assign bus.in_ready  = inReady;
    assign bus.out_valid = outValid_q;
    assign bus.out_match = outMatch_q;
    assign bus.out_hit   = outHit_q;
    assign bus.out_port  = outPort_q;
    assign miss_cnt_o    = missCnt_q;

endmodule

// File: tb/tb_dest_compare_unit.sv
// Testbench for dest_compare_unit: directed scenarios with literal expectations plus a randomized run
// checked every cycle against a table-based reference model. Mask checks follow DCU_MASK_EN.
module tb_dest_compare_unit;
    import dcu_pkg::*;

    localparam int ADDR_W    = 8;
    localparam int NUM_PORTS = 4;
    localparam int CNT_W     = 4;
    localparam int IDX_W     = 2;
    localparam int MISS_MAX  = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              cfgWe = 1'b0;
    logic [IDX_W-1:0]  cfgIdx = '0;
    logic [ADDR_W-1:0] cfgAddr = '0;
    logic              cfgEn = 1'b0;
    logic [ADDR_W-1:0] cfgMask = '0;
    logic              cntClr = 1'b0;
    logic [CNT_W-1:0]  missCnt;

    int checks   = 0;
    int failures = 0;

    dest_compare_unit_if #(.ADDR_W(ADDR_W), .NUM_PORTS(NUM_PORTS)) busIf ();

    dest_compare_unit #(
        .ADDR_W   (ADDR_W),
        .NUM_PORTS(NUM_PORTS),
        .CNT_W    (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_we_i  (cfgWe),
        .cfg_idx_i (cfgIdx),
        .cfg_addr_i(cfgAddr),
        .cfg_en_i  (cfgEn),
`ifdef DCU_MASK_EN
        .cfg_mask_i(cfgMask),
`endif
        .cnt_clr_i (cntClr),
        .miss_cnt_o(missCnt),
        .bus       (busIf)
    );

    always #5 clk = ~clk;

    // Reference model: the port table as plain arrays, and what the output register must hold.
    logic [ADDR_W-1:0]    mAddr [NUM_PORTS];
    logic                 mEn   [NUM_PORTS];
    logic [ADDR_W-1:0]    mMask [NUM_PORTS];
    logic                 mValid = 1'b0;
    logic [NUM_PORTS-1:0] mMatch = '0;
    logic                 mHit = 1'b0;
    int                   mPort = 0;
    int                   mMiss = 0;
    logic                 mAcc;
    logic [NUM_PORTS-1:0] nMatch;
    logic                 nHit;
    int                   nPort;

    initial begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            mAddr[i] = '0;
            mEn[i]   = 1'b0;
            mMask[i] = '0;
        end
    end

    function automatic void modelCompare(input logic [ADDR_W-1:0] addr,
                                         output logic [NUM_PORTS-1:0] m,
                                         output logic h, output int p);
        m = '0;
        h = 1'b0;
        p = 0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (mEn[i] && ((addr & ~mMask[i]) == (mAddr[i] & ~mMask[i]))) begin
                m[i] = 1'b1;
                if (!h) begin
                    p = i;
                    h = 1'b1;
                end
            end
        end
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                mAddr[i] = '0;
                mEn[i]   = 1'b0;
                mMask[i] = '0;
            end
            mValid = 1'b0;
            mMatch = '0;
            mHit   = 1'b0;
            mPort  = 0;
            mMiss  = 0;
        end else begin
            mAcc = busIf.in_valid && (!mValid || busIf.out_ready);
            nHit = 1'b0;
            if (mAcc) begin
                modelCompare(busIf.in_addr, nMatch, nHit, nPort);
                mValid = 1'b1;
                mMatch = nMatch;
                mHit   = nHit;
                mPort  = nPort;
            end else if (busIf.out_ready) begin
                mValid = 1'b0;
            end
            if (cntClr) begin
                mMiss = 0;
            end else if (mAcc && !nHit && mMiss < MISS_MAX) begin
                mMiss = mMiss + 1;
            end
            if (cfgWe && int'(cfgIdx) < NUM_PORTS) begin
                mAddr[cfgIdx] = cfgAddr;
                mEn[cfgIdx]   = cfgEn;
`ifdef DCU_MASK_EN
                mMask[cfgIdx] = cfgMask;
`endif
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison on the falling edge, well away from the sampling edge.
    always @(negedge clk) begin
        checkOutput("cyc_in_ready", 32'(busIf.in_ready), 32'(!mValid || busIf.out_ready));
        checkOutput("cyc_out_valid", 32'(busIf.out_valid), 32'(mValid));
        if (mValid) begin
            checkOutput("cyc_out_match", 32'(busIf.out_match), 32'(mMatch));
            checkOutput("cyc_out_hit", 32'(busIf.out_hit), 32'(mHit));
            checkOutput("cyc_out_port", 32'(busIf.out_port), 32'(mPort));
        end
        checkOutput("cyc_miss_cnt", 32'(missCnt), 32'(mMiss));
    end

    // Drive one cycle of inputs, let the edge take them, and return just after that edge.
    task automatic applyStimulus(input logic valid, input logic [ADDR_W-1:0] addr,
                                 input logic ready, input logic clr);
        busIf.in_valid  = valid;
        busIf.in_addr   = addr;
        busIf.out_ready = ready;
        cntClr          = clr;
        @(posedge clk);
        #1;
        cfgWe  = 1'b0;
        cntClr = 1'b0;
    endtask

    task automatic writeEntry(input int idx, input logic [ADDR_W-1:0] addr, input logic en,
                              input logic [ADDR_W-1:0] mask);
        cfgWe   = 1'b1;
        cfgIdx  = IDX_W'(idx);
        cfgAddr = addr;
        cfgEn   = en;
        cfgMask = mask;
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
    endtask

    initial begin
        busIf.in_valid  = 1'b0;
        busIf.in_addr   = '0;
        busIf.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset state
        checkOutput("rst_out_valid", 32'(busIf.out_valid), 32'h0);
        checkOutput("rst_in_ready", 32'(busIf.in_ready), 32'h1);
        checkOutput("rst_out_match", 32'(busIf.out_match), 32'h0);
        checkOutput("rst_out_hit", 32'(busIf.out_hit), 32'h0);
        checkOutput("rst_out_port", 32'(busIf.out_port), 32'h0);
        checkOutput("rst_miss_cnt", 32'(missCnt), 32'h0);

        // Empty table: every address misses
        applyStimulus(1'b1, 8'h00, 1'b1, 1'b0);
        checkOutput("t1_out_valid", 32'(busIf.out_valid), 32'h1);
        checkOutput("t1_out_hit", 32'(busIf.out_hit), 32'h0);
        checkOutput("t1_out_match", 32'(busIf.out_match), 32'h0);
        checkOutput("t1_miss_cnt", 32'(missCnt), 32'h1);
        applyStimulus(1'b0, '0, 1'b1, 1'b0);

        // Four distinct ports, back-to-back stream
        writeEntry(0, 8'h10, 1'b1, 8'h00);
        writeEntry(1, 8'h20, 1'b1, 8'h00);
        writeEntry(2, 8'h30, 1'b1, 8'h00);
        writeEntry(3, 8'h40, 1'b1, 8'h00);
        applyStimulus(1'b1, 8'h30, 1'b1, 1'b0);
        checkOutput("t2_port_a", 32'(busIf.out_port), 32'h2);
        checkOutput("t2_match_a", 32'(busIf.out_match), 32'h4);
        applyStimulus(1'b1, 8'h40, 1'b1, 1'b0);
        checkOutput("t2_valid_b", 32'(busIf.out_valid), 32'h1);
        checkOutput("t2_port_b", 32'(busIf.out_port), 32'h3);
        applyStimulus(1'b0, '0, 1'b1, 1'b0);

        // Duplicate entries: all bits set, lowest index reported
        writeEntry(1, 8'h55, 1'b1, 8'h00);
        writeEntry(3, 8'h55, 1'b1, 8'h00);
        applyStimulus(1'b1, 8'h55, 1'b1, 1'b0);
        checkOutput("t3_match", 32'(busIf.out_match), 32'ha);
        checkOutput("t3_port", 32'(busIf.out_port), 32'h1);
        applyStimulus(1'b0, '0, 1'b1, 1'b0);

        // Backpressure: result held, nothing accepted until released
        applyStimulus(1'b1, 8'h10, 1'b0, 1'b0);
        checkOutput("t4_first_port", 32'(busIf.out_port), 32'h0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 8'h30, 1'b0, 1'b0);
            checkOutput("t4_in_ready_low", 32'(busIf.in_ready), 32'h0);
            checkOutput("t4_hold_match", 32'(busIf.out_match), 32'h1);
            checkOutput("t4_hold_valid", 32'(busIf.out_valid), 32'h1);
        end
        applyStimulus(1'b1, 8'h30, 1'b1, 1'b0);
        checkOutput("t4_second_port", 32'(busIf.out_port), 32'h2);
        checkOutput("t4_second_match", 32'(busIf.out_match), 32'h4);
        applyStimulus(1'b0, '0, 1'b1, 1'b0);

        // Config write on the accept cycle uses the old table
        cfgWe   = 1'b1;
        cfgIdx  = 2'd0;
        cfgAddr = 8'hAA;
        cfgEn   = 1'b1;
        cfgMask = 8'h00;
        applyStimulus(1'b1, 8'hAA, 1'b1, 1'b0);
        checkOutput("t5_old_table_hit", 32'(busIf.out_hit), 32'h0);
        applyStimulus(1'b1, 8'hAA, 1'b1, 1'b0);
        checkOutput("t5_new_table_hit", 32'(busIf.out_hit), 32'h1);
        checkOutput("t5_new_table_port", 32'(busIf.out_port), 32'h0);
        applyStimulus(1'b0, '0, 1'b1, 1'b0);

        // Saturation at all-ones, then clear beats a simultaneous miss
        applyStimulus(1'b0, '0, 1'b1, 1'b1);
        checkOutput("t6_cleared", 32'(missCnt), 32'h0);
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b1, 8'hEE, 1'b1, 1'b0);
        end
        checkOutput("t6_saturated", 32'(missCnt), 32'hf);
        applyStimulus(1'b1, 8'hEE, 1'b1, 1'b1);
        checkOutput("t6_clear_priority", 32'(missCnt), 32'h0);
        applyStimulus(1'b0, '0, 1'b1, 1'b0);

        // Masked compare (exact compare when masking is not built in)
        writeEntry(0, 8'hA0, 1'b1, 8'h0F);
        writeEntry(1, 8'h00, 1'b0, 8'h00);
        writeEntry(2, 8'h00, 1'b0, 8'h00);
        writeEntry(3, 8'h00, 1'b0, 8'h00);
        applyStimulus(1'b1, 8'hA7, 1'b1, 1'b0);
`ifdef DCU_MASK_EN
        checkOutput("t7_masked_hit", 32'(busIf.out_hit), 32'h1);
        checkOutput("t7_masked_port", 32'(busIf.out_port), 32'h0);
`else
        checkOutput("t7_exact_miss", 32'(busIf.out_hit), 32'h0);
`endif
        applyStimulus(1'b1, 8'hB7, 1'b1, 1'b0);
        checkOutput("t7_unmasked_miss", 32'(busIf.out_hit), 32'h0);
        applyStimulus(1'b0, '0, 1'b1, 1'b0);

        // Randomized traffic with an asynchronous reset in the middle
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc == 1500) begin
                #2 rst_n = 1'b0;
                @(posedge clk);
                #1 rst_n = 1'b1;
                checkOutput("rnd_reset_valid", 32'(busIf.out_valid), 32'h0);
                checkOutput("rnd_reset_miss", 32'(missCnt), 32'h0);
            end
            if ($urandom_range(0, 7) == 0) begin
                cfgWe   = 1'b1;
                cfgIdx  = IDX_W'($urandom_range(0, NUM_PORTS - 1));
                cfgAddr = ADDR_W'($urandom_range(16, 23));
                cfgEn   = ($urandom_range(0, 3) != 0);
                cfgMask = ADDR_W'($urandom_range(0, 3));
            end
            applyStimulus($urandom_range(0, 9) < 7,
                          ($urandom_range(0, 3) == 0) ? ADDR_W'($urandom) : ADDR_W'($urandom_range(16, 23)),
                          $urandom_range(0, 9) < 7,
                          $urandom_range(0, 63) == 0);
        end

        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
